// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Byte FIFO from the CPU UART store port to the UART transmitter,
//            with optional LF -> LF,CR expansion and one send pulse per pop.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int                DATA_W      = 8,
    parameter int                DEPTH       = 256,
    parameter int                CRLF_EXPAND = 1,
    parameter logic [DATA_W-1:0] LF_CHAR     = 8'h0a,
    parameter logic [DATA_W-1:0] CR_CHAR     = 8'h0d
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       ready,
    output logic                       send,
    output logic [DATA_W-1:0]          datao,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic [15:0]                drop_cnt
);

    localparam int                c_AW       = $clog2(DEPTH);
    localparam int                c_CW       = c_AW + 1;
    localparam logic [c_CW-1:0]   c_DEPTH    = c_CW'(DEPTH);
    localparam logic [c_CW-1:0]   c_NEED_MAX = (CRLF_EXPAND != 0) ? c_CW'(2) : c_CW'(1);
    localparam logic [c_CW-1:0]   c_TWO      = c_CW'(2);
    localparam logic [c_CW-1:0]   c_ONE      = c_CW'(1);
    localparam logic [c_AW-1:0]   c_ONE_A    = c_AW'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]   r_head;
    logic [c_AW-1:0]   r_tail;
    logic [c_CW-1:0]   r_count;
    logic              r_send;
    logic [DATA_W-1:0] r_datao;
    logic              r_overflow;
    logic [15:0]       r_drop_cnt;

    logic [c_CW-1:0]   w_need;
    logic [c_CW-1:0]   w_free;
    logic [c_CW-1:0]   w_add;
    logic [c_CW-1:0]   w_sub;
    logic              w_accept;
    logic              w_reject;
    logic              w_pop;
    logic [c_AW-1:0]   w_tail_p1;

    // Space check uses start-of-cycle occupancy; a same-cycle pop never makes room.
    always_comb begin
        w_need    = ((CRLF_EXPAND != 0) && (in_data == LF_CHAR)) ? c_TWO : c_ONE;
        w_free    = c_DEPTH - r_count;
        w_accept  = in_valid && (w_free >= w_need);
        w_reject  = in_valid && !w_accept;
        w_pop     = ready && (r_count != '0) && !r_send;
        w_add     = w_accept ? w_need : '0;
        w_sub     = w_pop ? c_ONE : '0;
        w_tail_p1 = r_tail + c_ONE_A;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_send     <= 1'b0;
            r_datao    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_send  <= 1'b0;
        end else begin
            r_send  <= w_pop;
            r_count <= r_count + w_add - w_sub;
            if (w_pop) begin
                r_datao <= r_mem[r_head];
                r_head  <= r_head + c_ONE_A;
            end
            if (w_accept) begin
                r_tail <= r_tail + w_need[c_AW-1:0];
            end
            if (w_reject) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_accept) begin
            r_mem[r_tail] <= in_data;
            if (w_need == c_TWO) begin
                r_mem[w_tail_p1] <= CR_CHAR;
            end
        end
    end

    assign in_ready = (w_free >= c_NEED_MAX);
    assign send     = r_send;
    assign datao    = r_datao;
    assign count    = r_count;
    assign empty    = (r_count == '0);
    assign full     = (r_count == c_DEPTH);
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Directed self-checking bench; instance A is DEPTH=4 with LF
//            expansion, instance B is DEPTH=16 without expansion.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        a_rst, a_flush, a_in_valid, a_in_ready, a_ready, a_send, a_empty, a_full, a_overflow;
    logic [7:0]  a_in_data, a_datao;
    logic [2:0]  a_count;
    logic [15:0] a_drop_cnt;

    logic        b_rst, b_flush, b_in_valid, b_in_ready, b_ready, b_send, b_empty, b_full, b_overflow;
    logic [7:0]  b_in_data, b_datao;
    logic [4:0]  b_count;
    logic [15:0] b_drop_cnt;

    uart_tx_fifo #(.DATA_W(8), .DEPTH(4), .CRLF_EXPAND(1)) u_dut_a (
        .clk(clk), .rst(a_rst), .flush(a_flush), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .ready(a_ready), .send(a_send), .datao(a_datao), .count(a_count),
        .empty(a_empty), .full(a_full), .overflow(a_overflow), .drop_cnt(a_drop_cnt)
    );

    uart_tx_fifo #(.DATA_W(8), .DEPTH(16), .CRLF_EXPAND(0)) u_dut_b (
        .clk(clk), .rst(b_rst), .flush(b_flush), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .ready(b_ready), .send(b_send), .datao(b_datao), .count(b_count),
        .empty(b_empty), .full(b_full), .overflow(b_overflow), .drop_cnt(b_drop_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [7:0] d);
        a_in_valid = 1'b1; a_in_data = d; step(); a_in_valid = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] d);
        b_in_valid = 1'b1; b_in_data = d; step(); b_in_valid = 1'b0;
    endtask

    initial begin
        a_rst = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_ready = 1'b0;
        b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_ready = 1'b0;
        step(); step();
        a_rst = 1'b0; b_rst = 1'b0;

        // Reset state
        check("rst_count", 32'(a_count), 0);
        check("rst_empty", 32'(a_empty), 1);
        check("rst_full", 32'(a_full), 0);
        check("rst_send", 32'(a_send), 0);
        check("rst_datao", 32'(a_datao), 0);
        check("rst_ovf", 32'(a_overflow), 0);
        check("rst_drop", 32'(a_drop_cnt), 0);
        check("rst_in_ready", 32'(a_in_ready), 1);

        // Plain characters, alternate-cycle send pulses
        push_a(8'h41); push_a(8'h42); push_a(8'h43);
        check("t1_count3", 32'(a_count), 3);
        a_ready = 1'b1;
        step(); check("t1_send_a", 32'(a_send), 1); check("t1_data_a", 32'(a_datao), 32'h41);
        check("t1_count2", 32'(a_count), 2);
        step(); check("t1_gap1", 32'(a_send), 0); check("t1_hold", 32'(a_datao), 32'h41);
        step(); check("t1_send_b", 32'(a_send), 1); check("t1_data_b", 32'(a_datao), 32'h42);
        check("t1_count1", 32'(a_count), 1);
        step(); check("t1_gap2", 32'(a_send), 0);
        step(); check("t1_send_c", 32'(a_send), 1); check("t1_data_c", 32'(a_datao), 32'h43);
        check("t1_count0", 32'(a_count), 0); check("t1_empty", 32'(a_empty), 1);
        step(); check("t1_idle", 32'(a_send), 0);
        a_ready = 1'b0;

        // LF expansion on A
        push_a(8'h0a);
        check("t2_lf_count", 32'(a_count), 2);
        a_ready = 1'b1;
        step(); check("t2_lf_send", 32'(a_send), 1); check("t2_lf_data", 32'(a_datao), 32'h0a);
        step(); check("t2_gap", 32'(a_send), 0);
        step(); check("t2_cr_send", 32'(a_send), 1); check("t2_cr_data", 32'(a_datao), 32'h0d);
        check("t2_cr_count", 32'(a_count), 0);
        step();
        a_ready = 1'b0;

        // No expansion on B
        push_b(8'h0a);
        check("t2b_count", 32'(b_count), 1);
        b_ready = 1'b1;
        step(); check("t2b_send", 32'(b_send), 1); check("t2b_data", 32'(b_datao), 32'h0a);
        check("t2b_count0", 32'(b_count), 0);
        step(); step(); check("t2b_no_cr", 32'(b_send), 0);
        b_ready = 1'b0;

        // Overflow on small FIFO: LF needs two slots
        push_a(8'h61); push_a(8'h62); push_a(8'h63);
        check("t3_count3", 32'(a_count), 3);
        check("t3_in_ready0", 32'(a_in_ready), 0);
        push_a(8'h0a);
        check("t3_lf_drop_cnt", 32'(a_count), 3);
        check("t3_ovf", 32'(a_overflow), 1);
        check("t3_drop1", 32'(a_drop_cnt), 1);
        push_a(8'h64);
        check("t3_count4", 32'(a_count), 4); check("t3_full", 32'(a_full), 1);
        push_a(8'h65);
        check("t3_drop2", 32'(a_drop_cnt), 2); check("t3_count_full", 32'(a_count), 4);

        // Push in the pop cycle of a full FIFO is rejected
        a_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 8'h66;
        step(); a_in_valid = 1'b0;
        check("t4_send", 32'(a_send), 1); check("t4_data", 32'(a_datao), 32'h61);
        check("t4_count", 32'(a_count), 3); check("t4_drop3", 32'(a_drop_cnt), 3);
        step();
        step(); check("t4_d62", 32'(a_datao), 32'h62);
        step();
        step(); check("t4_d63", 32'(a_datao), 32'h63);
        step();
        step(); check("t4_d64", 32'(a_datao), 32'h64); check("t4_empty", 32'(a_empty), 1);
        step();

        // Pointer wrap over 3*DEPTH characters
        for (int i = 0; i < 12; i++) begin
            push_a(8'h30 + 8'(i));
            step();
            check("t4_wrap_send", 32'(a_send), 1);
            check("t4_wrap_data", 32'(a_datao), 32'h30 + 32'(i));
            step();
        end
        a_ready = 1'b0;

        // Flush keeps datao/overflow/drop_cnt
        push_a(8'ha1); push_a(8'ha2); push_a(8'ha3);
        a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 8'ha4; a_ready = 1'b1;
        step(); a_flush = 1'b0; a_in_valid = 1'b0;
        check("t5a_count", 32'(a_count), 0); check("t5a_send", 32'(a_send), 0);
        check("t5a_ovf", 32'(a_overflow), 1); check("t5a_drop", 32'(a_drop_cnt), 3);
        check("t5a_datao", 32'(a_datao), 32'h3b);
        step(); check("t5a_no_pop", 32'(a_send), 0);
        a_ready = 1'b0;

        for (int i = 0; i < 5; i++) push_b(8'h71 + 8'(i));
        check("t5b_count5", 32'(b_count), 5);
        b_flush = 1'b1; b_in_valid = 1'b1; b_in_data = 8'h76; b_ready = 1'b1;
        step(); b_flush = 1'b0; b_in_valid = 1'b0;
        check("t5b_count", 32'(b_count), 0); check("t5b_empty", 32'(b_empty), 1);
        check("t5b_send", 32'(b_send), 0); check("t5b_ovf", 32'(b_overflow), 0);
        check("t5b_drop", 32'(b_drop_cnt), 0); check("t5b_datao", 32'(b_datao), 32'h0a);
        step(); check("t5b_no_pop", 32'(b_send), 0);
        b_ready = 1'b0;

        // Reset during a send pulse
        for (int i = 0; i < 10; i++) push_b(8'h80 + 8'(i));
        check("t6_count10", 32'(b_count), 10);
        b_ready = 1'b1;
        step(); check("t6_send", 32'(b_send), 1); check("t6_data", 32'(b_datao), 32'h80);
        b_rst = 1'b1;
        step(); b_rst = 1'b0;
        check("t6_rst_send", 32'(b_send), 0); check("t6_rst_datao", 32'(b_datao), 0);
        check("t6_rst_count", 32'(b_count), 0); check("t6_rst_empty", 32'(b_empty), 1);
        step(); step(); check("t6_quiet", 32'(b_send), 0);
        push_b(8'h90);
        check("t6_new_count", 32'(b_count), 1);
        step(); check("t6_new_send", 32'(b_send), 1); check("t6_new_data", 32'(b_datao), 32'h90);
        b_ready = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
